seven_seg_scan_decoder: RTL and testbench
=========================================

Name: seven_seg_scan_decoder

Overview:
Receiver end of the seven-segment display interface. Samples a multiplexed, active-low seven-segment bus plus one-hot digit strobes, and debounces each digit pattern. Decodes the pattern back to a 4-bit value and assembles a full multi-digit frame, handed off through a val/rdy interface. Used in lab test harnesses and display-loopback checking, downstream of the binary-to-seven-segment encoders.

Parameters:
NDIGITS, 2, number of multiplexed digits (>=1)
STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (>=2)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
seg  input  7  segment lines, active-low; seg[0]=a … seg[6]=g
digit_en  input  NDIGITS  digit strobe, active-high, expected one-hot
out_val  output  1  frame valid
out_rdy  input  1  consumer ready
out_value  output  4*NDIGITS  digit i in bits [4i+3:4i]
out_err  output  1  frame contained at least one unrecognised pattern

Behaviour:
- Reset (rst=1 at an edge): out_val=0, out_value=0, out_err=0, state=COLLECT, capture mask=0, stability count=0, seg_q=7'h7F, en_q=0. Reset overrides everything, including a pending frame.
- Pattern decode, with {g..a} as seg[6:0]: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9. 1111111 (blank) -> 4'hE, not an error. Any other pattern -> 4'hF and sets the per-frame error bit.
- Stability counter, evaluated each cycle:
  - If digit_en is one-hot and (seg, digit_en) equals (seg_q, en_q): cnt <= min(cnt+1, STABLE_CYCLES).
  - Else if digit_en is one-hot: cnt <= 1.
  - Else (zero or multi-hot): cnt <= 0.
  - seg_q <= seg and en_q <= digit_en every cycle.
- Capture: occurs on the edge where the match holds and cnt==STABLE_CYCLES-1, i.e. the STABLE_CYCLES-th consecutive identical valid sample. At most one capture per stable episode; a saturated count never re-captures.
- On capture: the working register for the strobed digit <= decoded value, its mask bit <= 1, and the working error bit is ORed with the invalid flag.
- A digit captured again before frame completion is overwritten (last capture wins). Its error contribution remains sticky for the frame.
- FSM COLLECT:
  - On the edge where the mask becomes all-ones (including the capture on that edge), load out_value/out_err from the working registers (with that capture included) and go to PRESENT.
  - Clear the mask and working error on that same edge.
  - out_val is 1 from the following cycle.
- FSM PRESENT:
  - out_val=1; out_value and out_err are held stable.
  - Capture continues into the working registers and mask for the next frame.
  - When out_val && out_rdy: go to COLLECT and out_val <= 0.
  - If the mask is already full at the handshake edge, go straight back to PRESENT with the new frame, so out_val stays high and the data changes.
- Latency: last digit's pattern first presented at cycle t -> out_val high at cycle t+STABLE_CYCLES, if all other digits were already captured.
- Outputs depend only on registers, with no combinational path from inputs to outputs.

Decomposition:
- Shared include, also used by the encoders: active-low segment pattern constants for 0-9 and blank, the blank code 4'hE, and the invalid code 4'hF.
- One combinational sub-module, seven_seg_pattern_decode: 7-bit pattern in, 4-bit value plus invalid flag out. It is exhaustively testable on its own.

Test Plan:
- Reset, then all 128 seg patterns through seven_seg_pattern_decode -> the ten digit codes map to 0-9, 7'h7F maps to E, and everything else maps to F with invalid=1.
- NDIGITS=2, STABLE_CYCLES=4, out_rdy=1: digit_en=01 with seg=0110000 for 4 cycles, then digit_en=10 with seg=0010000 for 4 cycles -> out_val pulses 1 cycle, out_value=8'h93, out_err=0.
- Glitch: digit_en=01 with seg=0100100 for 3 cycles, then 1 cycle of 0000000, then back -> no capture until 4 fresh stable cycles. Garbage pattern 0101010 stable on digit 1 -> out_value[7:4]=F, out_err=1.
- Strobe faults: digit_en=00 or 11 held for 10 cycles with any seg -> no capture, mask unchanged, out_val stays 0.
- Backpressure: out_rdy=0 after frame 8'h21 is presented, then digits 5 and 7 are captured -> out_value stays 8'h21. When out_rdy rises, out_val stays high and the next cycle shows 8'h75.
- rst asserted while out_val=1 and a capture is mid-count -> next cycle out_val=0, out_value=0, and a fresh full frame is required.

Source files
------------

// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared definitions for the seven-segment receive path: active-low segment
// patterns ({g..a}), special decode codes and the frame FSM state type.
package seven_seg_scan_decoder_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK   = 4'hE;
    localparam logic [3:0] CODE_INVALID = 4'hF;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Frame hand-off interface: the decoder is the master driving val/value/err,
// the consumer is the slave driving rdy.
interface seven_seg_scan_decoder_if #(
    parameter int NDIGITS = 2
);
    logic                   out_val;
    logic                   out_rdy;
    logic [4*NDIGITS-1:0]   out_value;
    logic                   out_err;

    modport master (
        output out_val,
        output out_value,
        output out_err,
        input  out_rdy
    );

    modport slave (
        input  out_val,
        input  out_value,
        input  out_err,
        output out_rdy
    );
endinterface

// File: rtl/seven_seg_pattern_decode.sv
// Combinational inverse of the seven-segment encoder: maps an active-low
// pattern back to its digit, blank to E, anything else to F with invalid set.
module seven_seg_pattern_decode
    import seven_seg_scan_decoder_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       invalid
);

    // Full pattern lookup; unlisted patterns are the error case.
    always_comb begin
        value   = CODE_INVALID;
        invalid = 1'b1;
        case (pattern)
            SEG_0:     begin value = 4'h0;       invalid = 1'b0; end
            SEG_1:     begin value = 4'h1;       invalid = 1'b0; end
            SEG_2:     begin value = 4'h2;       invalid = 1'b0; end
            SEG_3:     begin value = 4'h3;       invalid = 1'b0; end
            SEG_4:     begin value = 4'h4;       invalid = 1'b0; end
            SEG_5:     begin value = 4'h5;       invalid = 1'b0; end
            SEG_6:     begin value = 4'h6;       invalid = 1'b0; end
            SEG_7:     begin value = 4'h7;       invalid = 1'b0; end
            SEG_8:     begin value = 4'h8;       invalid = 1'b0; end
            SEG_9:     begin value = 4'h9;       invalid = 1'b0; end
            SEG_BLANK: begin value = CODE_BLANK; invalid = 1'b0; end
            default:   begin value = CODE_INVALID; invalid = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Samples a multiplexed seven-segment bus, debounces each strobed digit,
// and presents completed multi-digit frames over a val/rdy interface.
module seven_seg_scan_decoder
    import seven_seg_scan_decoder_pkg::*;
#(
    parameter int NDIGITS       = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NDIGITS-1:0]      digit_en,
    seven_seg_scan_decoder_if.master out_if
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]      CNT_CAP   = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]      CNT_MAX   = CW'(STABLE_CYCLES);
    localparam logic [NDIGITS-1:0] MASK_NONE = {NDIGITS{1'b0}};
    localparam logic [NDIGITS-1:0] MASK_FULL = {NDIGITS{1'b1}};
    localparam logic [NDIGITS-1:0] EN_ONE    = NDIGITS'(1);

    logic [6:0]           seg_q,       seg_d;
    logic [NDIGITS-1:0]   en_q,        en_d;
    logic [CW-1:0]        cnt_q,       cnt_d;
    logic [NDIGITS-1:0]   mask_q,      mask_d;
    logic [4*NDIGITS-1:0] work_q,      work_d;
    logic                 werr_q,      werr_d;
    state_e               state_q,     state_d;
    logic                 out_val_q,   out_val_d;
    logic [4*NDIGITS-1:0] out_value_q, out_value_d;
    logic                 out_err_q,   out_err_d;

    logic [3:0]           dec_value_s;
    logic                 dec_invalid_s;
    logic                 onehot_s;
    logic                 match_s;
    logic                 capture_s;
    logic [NDIGITS-1:0]   mask_next_s;
    logic [4*NDIGITS-1:0] work_next_s;
    logic                 werr_next_s;
    logic                 full_s;

    seven_seg_pattern_decode u_decode (
        .pattern (seg),
        .value   (dec_value_s),
        .invalid (dec_invalid_s)
    );

    // Debounce and capture: decide this cycle's capture and the resulting working frame.
    always_comb begin
        onehot_s    = (digit_en != MASK_NONE) &&
                      ((digit_en & (digit_en - EN_ONE)) == MASK_NONE);
        match_s     = onehot_s && (seg == seg_q) && (digit_en == en_q);
        // Capture fires only on the exact transition into STABLE_CYCLES, so a
        // saturated count never re-captures the same episode.
        capture_s   = match_s && (cnt_q == CNT_CAP);

        if (match_s) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);
        end else if (onehot_s) begin
            cnt_d = CNT_ONE;
        end else begin
            cnt_d = {CW{1'b0}};
        end
        seg_d = seg;
        en_d  = digit_en;

        work_next_s = work_q;
        for (int i = 0; i < NDIGITS; i++) begin
            if (capture_s && digit_en[i]) begin
                work_next_s[4*i +: 4] = dec_value_s;
            end else begin
                work_next_s[4*i +: 4] = work_q[4*i +: 4];
            end
        end
        mask_next_s = capture_s ? (mask_q | digit_en) : mask_q;
        werr_next_s = werr_q | (capture_s & dec_invalid_s);
        full_s      = (mask_next_s == MASK_FULL);
    end

    // Frame FSM: hand a full working frame to the output registers and clear the mask.
    always_comb begin
        state_d     = state_q;
        out_val_d   = out_val_q;
        out_value_d = out_value_q;
        out_err_d   = out_err_q;
        work_d      = work_next_s;
        mask_d      = mask_next_s;
        werr_d      = werr_next_s;
        case (state_q)
            ST_COLLECT: begin
                if (full_s) begin
                    out_value_d = work_next_s;
                    out_err_d   = werr_next_s;
                    mask_d      = MASK_NONE;
                    werr_d      = 1'b0;
                    out_val_d   = 1'b1;
                    state_d     = ST_PRESENT;
                end else begin
                    out_val_d   = 1'b0;
                    state_d     = ST_COLLECT;
                end
            end
            ST_PRESENT: begin
                // While held, collection continues; a frame already complete at
                // the handshake goes straight out without dropping out_val.
                if (out_val_q && out_if.out_rdy) begin
                    if (full_s) begin
                        out_value_d = work_next_s;
                        out_err_d   = werr_next_s;
                        mask_d      = MASK_NONE;
                        werr_d      = 1'b0;
                        out_val_d   = 1'b1;
                        state_d     = ST_PRESENT;
                    end else begin
                        out_val_d   = 1'b0;
                        state_d     = ST_COLLECT;
                    end
                end else begin
                    out_val_d = 1'b1;
                    state_d   = ST_PRESENT;
                end
            end
            default: begin
                out_val_d = 1'b0;
                mask_d    = MASK_NONE;
                werr_d    = 1'b0;
                state_d   = ST_COLLECT;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q       <= SEG_BLANK;
            en_q        <= MASK_NONE;
            cnt_q       <= {CW{1'b0}};
            mask_q      <= MASK_NONE;
            work_q      <= {(4*NDIGITS){1'b0}};
            werr_q      <= 1'b0;
            state_q     <= ST_COLLECT;
            out_val_q   <= 1'b0;
            out_value_q <= {(4*NDIGITS){1'b0}};
            out_err_q   <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            en_q        <= en_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            work_q      <= work_d;
            werr_q      <= werr_d;
            state_q     <= state_d;
            out_val_q   <= out_val_d;
            out_value_q <= out_value_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_if.out_val   = out_val_q;
    assign out_if.out_value = out_value_q;
    assign out_if.out_err   = out_err_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed self-checking bench for seven_seg_scan_decoder and its pattern decoder.
module tb_seven_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic [1:0] digit_en;
    logic [6:0] dec_pat;
    logic [3:0] dec_val;
    logic       dec_inv;
    int         checks = 0;
    int         errors = 0;

    seven_seg_scan_decoder_if #(.NDIGITS(2)) dut_if ();

    seven_seg_scan_decoder #(.NDIGITS(2), .STABLE_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg      (seg),
        .digit_en (digit_en),
        .out_if   (dut_if)
    );

    seven_seg_pattern_decode u_dec (
        .pattern (dec_pat),
        .value   (dec_val),
        .invalid (dec_inv)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] dec_ref(input logic [6:0] p);
        case (p)
            7'b1000000: return 5'h00;
            7'b1111001: return 5'h01;
            7'b0100100: return 5'h02;
            7'b0110000: return 5'h03;
            7'b0011001: return 5'h04;
            7'b0010010: return 5'h05;
            7'b0000010: return 5'h06;
            7'b1111000: return 5'h07;
            7'b0000000: return 5'h08;
            7'b0010000: return 5'h09;
            7'b1111111: return 5'h0E;
            default:    return 5'h1F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [1:0] en, input logic [6:0] s, input int n);
        digit_en = en;
        seg      = s;
        step(n);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] val, input logic e);
        check({tag, "_val"},   {31'd0, dut_if.out_val}, {31'd0, v});
        check({tag, "_value"}, {24'd0, dut_if.out_value}, {24'd0, val});
        check({tag, "_err"},   {31'd0, dut_if.out_err}, {31'd0, e});
    endtask

    initial begin
        rst = 1'b1;
        seg = 7'h7F;
        digit_en = 2'b00;
        dec_pat = 7'h00;
        dut_if.out_rdy = 1'b1;
        step(2);
        check_out("reset", 1'b0, 8'h00, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 128; i++) begin
            dec_pat = 7'(i);
            #1;
            check("decode", {27'd0, dec_inv, dec_val}, {27'd0, dec_ref(7'(i))});
        end

        // Basic frame 8'h93 with latency check
        drive(2'b01, 7'b0110000, 4);
        check("d0_only_val", {31'd0, dut_if.out_val}, 32'd0);
        drive(2'b10, 7'b0010000, 3);
        check("latency_early", {31'd0, dut_if.out_val}, 32'd0);
        step(1);
        check_out("frame93", 1'b1, 8'h93, 1'b0);
        drive(2'b00, 7'h7F, 1);
        check_out("frame93_ack", 1'b0, 8'h93, 1'b0);

        // Glitch restarts the debounce; garbage digit sets error
        drive(2'b01, 7'b0100100, 3);
        drive(2'b01, 7'b0000000, 1);
        drive(2'b01, 7'b0100100, 3);
        drive(2'b10, 7'b0101010, 4);
        check("glitch_no_cap", {31'd0, dut_if.out_val}, 32'd0);
        drive(2'b01, 7'b0100100, 4);
        check_out("frameF2", 1'b1, 8'hF2, 1'b1);
        drive(2'b00, 7'h7F, 1);
        check("frameF2_ack", {31'd0, dut_if.out_val}, 32'd0);

        // Strobe faults leave the mask untouched
        dut_if.out_rdy = 1'b0;
        drive(2'b01, 7'b1111001, 4);
        drive(2'b00, 7'b0110000, 10);
        check("fault_zero", {31'd0, dut_if.out_val}, 32'd0);
        drive(2'b11, 7'b0110000, 10);
        check("fault_multi", {31'd0, dut_if.out_val}, 32'd0);
        drive(2'b10, 7'b0100100, 3);
        check("frame21_early", {31'd0, dut_if.out_val}, 32'd0);
        step(1);
        check_out("frame21", 1'b1, 8'h21, 1'b0);

        // Backpressure: output held while next frame assembles
        drive(2'b01, 7'b0010010, 4);
        check_out("bp_hold1", 1'b1, 8'h21, 1'b0);
        drive(2'b10, 7'b1111000, 4);
        check_out("bp_hold2", 1'b1, 8'h21, 1'b0);
        dut_if.out_rdy = 1'b1;
        drive(2'b00, 7'h7F, 1);
        check_out("frame75", 1'b1, 8'h75, 1'b0);
        step(1);
        check("frame75_ack", {31'd0, dut_if.out_val}, 32'd0);

        // Reset while presenting and mid-capture
        dut_if.out_rdy = 1'b0;
        drive(2'b01, 7'b0110000, 4);
        drive(2'b10, 7'b0010000, 4);
        check_out("pre_rst", 1'b1, 8'h93, 1'b0);
        drive(2'b01, 7'b1000000, 4);
        drive(2'b10, 7'b0000000, 2);
        rst = 1'b1;
        step(1);
        check_out("mid_rst", 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        dut_if.out_rdy = 1'b1;
        drive(2'b10, 7'b1111001, 4);
        check("post_rst_partial", {31'd0, dut_if.out_val}, 32'd0);
        drive(2'b01, 7'b0011001, 4);
        check_out("frame14", 1'b1, 8'h14, 1'b0);
        drive(2'b00, 7'h7F, 1);
        check("frame14_ack", {31'd0, dut_if.out_val}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
